// File: rtl/fifo_pkt_framer.sv
// Drains a 16-bit synchronous FIFO one word at a time and frames every PKT_WORDS words plus a sum checksum.
// Latency: 3 cycles from IDLE seeing a non-empty FIFO to m_valid_o; 4 cycles per payload word, 1 per checksum.
// Backpressure: one word in flight; m_ready_i low holds the beat and blocks further pops, empty FIFO holds in IDLE.
module fifo_pkt_framer #(
  parameter int DATA_W    = 16,
  parameter int PKT_WORDS = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_rd_en_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic [7:0]        pkt_count_o
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    SEND,
    CKS
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(PKT_WORDS - 1);

  state_t            state;
  logic [7:0]        idx;
  logic [DATA_W-1:0] sum;

  // Framing FSM; every output is a register set on the transition into the state that owns it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      idx          <= 8'd0;
      sum          <= '0;
      fifo_rd_en_o <= 1'b0;
      m_data_o     <= '0;
      m_valid_o    <= 1'b0;
      m_last_o     <= 1'b0;
      pkt_count_o  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          // The empty flag is only looked at here, so a stalled packet keeps idx and sum.
          if (!fifo_empty_i) begin
            state        <= RD;
            fifo_rd_en_o <= 1'b1;
          end
        end
        RD: begin
          fifo_rd_en_o <= 1'b0;
          state        <= LAT;
        end
        LAT: begin
          // FIFO read data is valid the cycle after the pop.
          m_data_o  <= fifo_data_i;
          sum       <= sum + fifo_data_i;
          m_valid_o <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (m_ready_i) begin
            if (idx == LAST_IDX) begin
              // sum already includes this word, so the checksum beat follows directly.
              idx      <= 8'd0;
              m_data_o <= sum;
              m_last_o <= 1'b1;
              state    <= CKS;
            end else begin
              idx       <= idx + 8'd1;
              m_valid_o <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        CKS: begin
          if (m_ready_i) begin
            sum         <= '0;
            pkt_count_o <= pkt_count_o + 8'd1;
            m_valid_o   <= 1'b0;
            m_last_o    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          fifo_rd_en_o <= 1'b0;
          m_valid_o    <= 1'b0;
          m_last_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Bench for fifo_pkt_framer with a behavioural FIFO and a beat scoreboard.
// Latency: expected beats are queued when words enter the FIFO and retired on each handshake.
// Backpressure: m_ready_i is driven by the stimulus; stalled beats are checked for stability.
module tb_fifo_pkt_framer;
  localparam int DATA_W    = 16;
  localparam int PKT_WORDS = 4;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] dat;
  } beat_t;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              fifo_empty_i;
  logic [DATA_W-1:0] fifo_data_i;
  logic              fifo_rd_en_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_valid_o;
  logic              m_ready_i = 1'b1;
  logic              m_last_o;
  logic [7:0]        pkt_count_o;

  logic              push_vld  = 1'b0;
  logic [DATA_W-1:0] push_dat  = '0;
  logic              flush_req = 1'b0;

  logic [DATA_W-1:0] fifo_q[$];
  beat_t             exp_q[$];
  logic [DATA_W-1:0] mdl_sum = '0;
  int                widx    = 0;

  int                n_chk    = 0;
  int                n_pass   = 0;
  int                rd_cnt   = 0;
  int                beats    = 0;
  int                last_cnt = 0;
  logic [7:0]        exp_pkt  = 8'd0;
  logic [DATA_W-1:0] last_dat = '0;

  always #5 clk_i = ~clk_i;

  fifo_pkt_framer #(.DATA_W(DATA_W), .PKT_WORDS(PKT_WORDS)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_last_o     (m_last_o),
    .pkt_count_o  (pkt_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // FIFO model and monitor: sample at negedge, apply FIFO updates just after posedge.
  initial begin
    logic              pop_req, push_req, flush;
    logic [DATA_W-1:0] pdat, prev_data;
    logic              prev_stall, prev_rd, prev_last;
    beat_t             e;
    prev_stall   = 1'b0;
    prev_rd      = 1'b0;
    prev_data    = '0;
    prev_last    = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_data_i  = '0;
    forever begin
      @(negedge clk_i);
      pop_req  = fifo_rd_en_o;
      push_req = push_vld;
      pdat     = push_dat;
      flush    = flush_req;
      if (rst_i) begin
        exp_pkt    = 8'd0;
        prev_stall = 1'b0;
        prev_rd    = 1'b0;
      end else begin
        if (fifo_rd_en_o) begin
          chk("rd_while_valid", m_valid_o, 0);
          chk("rd_on_empty", fifo_empty_i, 0);
          chk("rd_pulse_width", prev_rd, 0);
          rd_cnt++;
        end
        prev_rd = fifo_rd_en_o;
        if (prev_stall) begin
          chk("stall_valid", m_valid_o, 1);
          chk("stall_data", m_data_o, prev_data);
          chk("stall_last", m_last_o, prev_last);
        end
        if (!m_valid_o) chk("last_low", m_last_o, 0);
        chk("pkt_count", pkt_count_o, exp_pkt);
        if (m_valid_o && m_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("beat_expected", 32'(exp_q.size()), 1);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_data_o, e.dat);
            chk("beat_last", m_last_o, e.last);
          end
          beats++;
          if (m_last_o) begin
            last_cnt++;
            exp_pkt++;
            last_dat = m_data_o;
          end
        end
        prev_stall = m_valid_o && !m_ready_i;
        prev_data  = m_data_o;
        prev_last  = m_last_o;
      end
      @(posedge clk_i);
      #1;
      if (flush) begin
        fifo_q.delete();
        exp_q.delete();
        mdl_sum = '0;
        widx    = 0;
      end else begin
        if (pop_req && fifo_q.size() > 0) fifo_data_i = fifo_q.pop_front();
        if (push_req) begin
          fifo_q.push_back(pdat);
          exp_q.push_back('{last: 1'b0, dat: pdat});
          mdl_sum = mdl_sum + pdat;
          widx++;
          if (widx == PKT_WORDS) begin
            exp_q.push_back('{last: 1'b1, dat: mdl_sum});
            mdl_sum = '0;
            widx    = 0;
          end
        end
      end
      fifo_empty_i = (fifo_q.size() == 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    @(posedge clk_i);
    #2;
    push_vld = 1'b1;
    push_dat = d;
    @(posedge clk_i);
    #2;
    push_vld = 1'b0;
  endtask

  task automatic wait_beats(input int target, input string tag);
    int k = 0;
    while (beats < target && k < 2000) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(beats >= target), 1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!m_valid_o && k < 200) begin
      tick(1);
      k++;
    end
    chk(tag, m_valid_o, 1);
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || m_valid_o) && k < 20000) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(exp_q.size()), 0);
    tick(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, fifo_rd_en_o, 0);
    chk({tag, "_valid"}, m_valid_o, 0);
    chk({tag, "_last"}, m_last_o, 0);
    chk({tag, "_data"}, m_data_o, 0);
    chk({tag, "_pkt_count"}, pkt_count_o, 0);
  endtask

  initial begin
    int r0, b0, k, l0;
    logic [7:0] p0;
    #1;
    rst_i = 1'b1;
    tick(2);
    check_reset_outputs("reset");
    rst_i = 1'b0;

    // Empty FIFO after reset: nothing may be popped or sent.
    tick(20);
    chk("empty_rd_cnt", rd_cnt, 0);
    chk("empty_valid", m_valid_o, 0);

    // Basic packet with first-beat latency and pop count.
    r0 = rd_cnt;
    push(16'h0001);
    k = 0;
    while (!m_valid_o && k < 20) begin
      tick(1);
      k++;
    end
    chk("first_valid_latency", k, 3);
    push(16'h0002);
    push(16'h0003);
    push(16'h0004);
    wait_drain("t1_drain");
    chk("t1_rd_pulses", rd_cnt - r0, 4);
    chk("t1_pkt_count", pkt_count_o, 1);
    chk("t1_cks", last_dat, 16'h000A);

    // Carry out of bit 15 is dropped.
    push(16'hFFFF);
    push(16'h0002);
    push(16'h0000);
    push(16'h0000);
    wait_drain("t2_drain");
    chk("t2_cks", last_dat, 16'h0001);

    // Backpressure on the second word.
    b0 = beats;
    push(16'h1111);
    wait_beats(b0 + 1, "t3_word1");
    m_ready_i = 1'b0;
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    wait_valid("t3_word2_valid");
    r0 = rd_cnt;
    tick(10);
    chk("t3_stall_rd", rd_cnt - r0, 0);
    chk("t3_stall_valid", m_valid_o, 1);
    chk("t3_stall_data", m_data_o, 16'h2222);
    m_ready_i = 1'b1;
    wait_drain("t3_drain");
    chk("t3_cks", last_dat, 16'hAAAA);

    // FIFO runs empty mid-packet.
    b0 = beats;
    push(16'h0100);
    push(16'h0200);
    wait_beats(b0 + 2, "t4_two_words");
    r0 = rd_cnt;
    tick(20);
    chk("t4_empty_rd", rd_cnt - r0, 0);
    chk("t4_empty_valid", m_valid_o, 0);
    push(16'h0300);
    push(16'h0400);
    wait_drain("t4_drain");
    chk("t4_cks", last_dat, 16'h0A00);

    // Reset mid-packet discards the partial packet.
    b0 = beats;
    push(16'h0ABC);
    push(16'h0DEF);
    wait_beats(b0 + 2, "t5_two_words");
    push(16'h0555);
    rst_i     = 1'b1;
    flush_req = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    tick(2);
    flush_req = 1'b0;
    rst_i     = 1'b0;
    tick(1);
    for (int i = 0; i < PKT_WORDS; i++) push(16'h0010);
    wait_drain("t5_drain");
    chk("t5_cks", last_dat, 16'h0040);
    chk("t5_pkt_count", pkt_count_o, 1);

    // 256 packets wrap the packet counter.
    p0 = pkt_count_o;
    l0 = last_cnt;
    for (int i = 0; i < 256 * PKT_WORDS; i++) push(16'($urandom));
    wait_drain("t6_drain");
    chk("t6_last_beats", last_cnt - l0, 256);
    chk("t6_pkt_wrap", pkt_count_o, p0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_pkt_framer.md
# fifo_pkt_framer

Read-side consumer for the 16-bit synchronous FIFO. It drains the FIFO one word at a time through its read port and never pops while the FIFO reports empty. It groups every PKT_WORDS payload words into a packet and appends a 16-bit checksum word. Each word goes out on a valid/ready stream toward the link/transmit stage.

## Interface
- DATA_W, 16, payload and checksum word width (matches FIFO data width)
- PKT_WORDS, 4, payload words per packet (legal range 1..255)
- clk_i  input  1  single clock; all state changes on rising edge
- rst_i  input  1  asynchronous, active-high reset
- fifo_empty_i  input  1  FIFO empty flag
- fifo_data_i  input  DATA_W  FIFO read data; valid the cycle after fifo_rd_en_o is high
- fifo_rd_en_o  output  1  FIFO pop request, one-cycle pulse per word
- m_data_o  output  DATA_W  stream data
- m_valid_o  output  1  stream data valid
- m_ready_i  input  1  downstream accepts when high with m_valid_o
- m_last_o  output  1  high on the checksum word (last beat of packet)
- pkt_count_o  output  8  completed packets, wraps 255 -> 0

## Operation
- FSM states:
  - IDLE: if fifo_empty_i=0, go to RD; otherwise stay in IDLE.
  - RD: fifo_rd_en_o=1. Go to LAT unconditionally.
  - LAT: capture fifo_data_i into m_data_o. sum <= sum + fifo_data_i. Go to SEND.
  - SEND: m_valid_o=1. On m_ready_i=1:
    - if idx = PKT_WORDS-1, idx <= 0 and go to CKS;
    - else idx <= idx+1 and go to IDLE.
  - CKS: m_data_o=sum, m_valid_o=1, m_last_o=1. On m_ready_i=1: sum <= 0, pkt_count_o <= pkt_count_o+1 (mod 256), go to IDLE.
- Checksum: two's-complement sum modulo 2^16 of the packet's payload words; carries are discarded.
- idx: 8-bit payload-word index within the current packet.
- At most one word is in flight. fifo_rd_en_o is never asserted outside RD, so there is never a pop on an empty FIFO and never a pop while an output word is pending.
- fifo_empty_i is sampled only in IDLE. An empty FIFO in IDLE holds the block indefinitely, including mid-packet; idx and sum are preserved.
- m_data_o, m_valid_o and m_last_o are stable while m_valid_o=1 and m_ready_i=0.
- m_last_o=0 in every state other than CKS.

## Timing
- All outputs are state-decoded or registered (Moore); there are no combinational paths from input to output.
- Reset values: fifo_rd_en_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, pkt_count_o=0. Internal: sum=0, idx=0, state IDLE.
- Reset takes effect immediately, independent of clk_i.
- Per-word latency, from an edge seeing IDLE with fifo_empty_i=0:
  - cycle +1: RD, fifo_rd_en_o high
  - cycle +2: LAT
  - cycle +3: SEND, m_valid_o high
- Throughput with the FIFO never empty and m_ready_i tied high: 4 cycles per payload word plus 1 cycle for the checksum. A PKT_WORDS=4 packet takes 17 cycles.
- Reset mid-packet: partial sum and idx are discarded. A word already popped (RD or LAT) is lost, and no partial packet or checksum is emitted. The first packet after reset checksums only words popped after reset.
- Simultaneous events: fifo_empty_i changes outside IDLE have no effect. m_ready_i while m_valid_o=0 is ignored.

## Test plan
- PKT_WORDS=4; push 0x0001, 0x0002, 0x0003, 0x0004; m_ready_i=1 -> beats 0x0001, 0x0002, 0x0003, 0x0004, then 0x000A with m_last_o=1. pkt_count_o goes 0 -> 1 on the checksum handshake. Exactly 4 fifo_rd_en_o pulses; first m_valid_o 3 cycles after the IDLE edge.
- Push 0xFFFF, 0x0002, 0x0000, 0x0000 -> checksum 0x0001 (carry dropped).
- Backpressure: m_ready_i=0 for 10 cycles during word 2 -> m_data_o and m_valid_o stable for all 10 cycles, no fifo_rd_en_o pulse; the packet resumes and checksums correctly.
- Empty FIFO: fifo_empty_i=1 for 20 cycles from reset, then after 2 of 4 words -> no fifo_rd_en_o, m_valid_o=0. After more words arrive, the packet completes with the correct sum.
- Reset mid-packet: assert rst_i after 2 accepted words -> all outputs 0 immediately. The next 4 words 0x0010 each yield checksum 0x0040.
- Push 256 packets -> pkt_count_o wraps 255 -> 0, and m_last_o appears on exactly 256 beats.
